instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage plus IF/ID register directly upstream of the main decoder (Control).
//  - Drives the instruction-memory handshake from the PC.
//  - Holds the fetched word in IF/ID and presents OpCode/Funct to the decoder.
//  - Applies PCSrc/Branch redirects coming back from decode. No delay slot.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; address of the first fetch
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset          in   1   asynchronous, active-low reset
//  imem_addr      out  32  fetch address; word aligned
//  imem_req       out  1   fetch request
//  imem_rdata     in   32  instruction word; valid when imem_ready=1
//  imem_ready     in   1   request accepted and data returned this cycle
//  stall          in   1   hazard unit: freeze IF/ID and suppress redirects
//  PCSrc          in   2   from decoder: 00 seq, 01 j/jal, 10 jr/jalr
//  Branch         in   1   from decoder: beq in ID
//  branch_taken   in   1   beq condition true (valid with Branch)
//  branch_target  in   32  ID pc_plus4 + (sext(imm)<<2)
//  jr_target      in   32  rs register value for jr/jalr
//  id_instr       out  32  IF/ID instruction
//  id_pc_plus4    out  32  IF/ID address+4 of id_instr
//  id_valid       out  1   IF/ID holds a real instruction
//  OpCode         out  6   id_instr[31:26]
//  Funct          out  6   id_instr[5:0]
// BEHAVIOUR
//  Reset values:
//  - pc=RESET_PC, state=FETCH, imem_req=0.
//  - id_instr=0, id_pc_plus4=0, id_valid=0, buf=0.
//  - id_instr=0 decodes as sll $0 (nop).
//  imem_addr = pc in FETCH/DROP; held at pc while stable.
//  Request rule:
//  - imem_req=1 in FETCH and DROP; 0 in HOLD. First request the cycle after reset release.
//  - Once raised, imem_req and imem_addr stay constant until imem_ready=1.
//  Redirect:
//  - redir = id_valid & ~stall & (PCSrc!=00 | (Branch & branch_taken)).
//  - Target (priority order): PCSrc=01 -> {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
//    PCSrc=10 -> jr_target; else branch_target.
//  - On redir: IF/ID squashed (id_valid=0, id_instr=0).
//  - At most one redirect per instruction; squash guarantees this.
//  PC arithmetic: pc+4 modulo 2^32; FFFF_FFFC wraps to 0000_0000.
//  FSM (accept = imem_ready in FETCH):
//  - FETCH, redir, ready:            discard rdata; pc<=target; stay FETCH.
//  - FETCH, redir, ~ready:           tgt<=target; ->DROP.
//  - FETCH, accept, ~stall:          IF/ID<={rdata, pc+4, 1}; pc<=pc+4.
//  - FETCH, accept, stall:           buf<={rdata, pc+4}; pc<=pc+4; ->HOLD.
//  - FETCH, ~ready, ~stall, ~redir:  IF/ID<=bubble.
//  - HOLD, redir:                    drop buf; pc<=target; ->FETCH.
//  - HOLD, ~stall:                   IF/ID<=buf; ->FETCH.
//  - HOLD, stall:                    hold.
//  - DROP, ready:                    discard rdata; pc<=tgt; ->FETCH.
//  - DROP, ~ready:                   hold; IF/ID stays squashed.
//  - stall=1 (any state): IF/ID holds its value.
//  Latency: word accepted at edge N appears on id_instr after edge N (same edge).
//  Reset mid-operation: outstanding request abandoned; memory tolerates imem_req dropping.
// TESTING
//  1. Release reset, imem_ready=1 always -> addr 0,4,8,... one per cycle;
//     id_valid=1 from 2nd edge.
//  2. IF/ID=j 0x0000100 (instr 0x08000040) -> id_valid=0 next cycle;
//     next imem_addr=0x00000100.
//  3. jr issued while imem_ready=0 for 3 cycles -> addr held; returned word discarded;
//     then addr=jr_target, e.g. 0x00000200.
//  4. stall=1 when ready returns 0x20080005 -> HOLD, imem_req=0, IF/ID unchanged;
//     stall drop -> id_instr=0x20080005.
//  5. RESET_PC=32'hFFFF_FFFC -> fetch FFFF_FFFC, then 0000_0000;
//     id_pc_plus4=0 for first word.
//  6. Assert reset low mid-wait -> all outputs at reset values immediately;
//     fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Fetch stage and IF/ID register: drives the instruction-memory handshake from the PC,
// holds the fetched word for the decoder and applies jump/branch redirects with no delay slot.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        started_q;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;

  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        ready_seen;

  // Handshake: imem_req/imem_addr are held stable until imem_ready=1 completes the transfer;
  // imem_ready is ignored whenever no request is outstanding.
  assign imem_req    = started_q && (state_q != S_HOLD);
  assign imem_addr   = pc_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pc4_q;
  assign id_valid    = valid_q;
  assign OpCode      = instr_q[31:26];
  assign Funct       = instr_q[5:0];
  assign dbg_state   = state_q;

  assign pc_plus4   = pc_q + 32'd4;
  assign ready_seen = started_q && imem_ready;
  assign redir      = valid_q && !stall && ((PCSrc != 2'b00) || (Branch && branch_taken));

  always_comb begin
    target = branch_target;
    if (PCSrc == 2'b01)      target = {pc4_q[31:28], instr_q[25:0], 2'b00};
    else if (PCSrc == 2'b10) target = jr_target;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    unique case (state_q)
      S_FETCH: begin
        if (redir) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
          if (ready_seen) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = S_DROP;
          end
        end else if (ready_seen) begin
          pc_d = pc_plus4;
          if (!stall) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_plus4;
            state_d     = S_HOLD;
          end
        end else if (!stall) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redir) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
          pc_d    = target;
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d = buf_instr_q;
          pc4_d   = buf_pc4_q;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        // The word answering the stale address is thrown away; IF/ID stays squashed.
        if (ready_seen) begin
          pc_d    = tgt_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      tgt_q       <= 32'h0;
      started_q   <= 1'b0;
      instr_q     <= 32'h0;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_pc4_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      started_q   <= 1'b1;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: a cycle-by-cycle vector table for the main sequence,
// then hand-written sequences for mid-wait reset and a wrapping RESET_PC.
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic [1:0]  PCSrc;
  logic        Branch;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [1:0]  dbg_state;

  logic        b_reset;
  logic [31:0] b_imem_addr;
  logic        b_imem_req;
  logic [31:0] b_imem_rdata;
  logic        b_imem_ready;
  logic [31:0] b_id_instr;
  logic [31:0] b_id_pc_plus4;
  logic        b_id_valid;
  logic [5:0]  b_OpCode;
  logic [5:0]  b_Funct;
  logic [1:0]  b_dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .PCSrc(PCSrc), .Branch(Branch), .branch_taken(branch_taken),
    .branch_target(branch_target), .jr_target(jr_target),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .OpCode(OpCode), .Funct(Funct), .dbg_state(dbg_state)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(b_reset),
    .imem_addr(b_imem_addr), .imem_req(b_imem_req),
    .imem_rdata(b_imem_rdata), .imem_ready(b_imem_ready),
    .stall(1'b0), .PCSrc(2'b00), .Branch(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .jr_target(32'h0),
    .id_instr(b_id_instr), .id_pc_plus4(b_id_pc_plus4), .id_valid(b_id_valid),
    .OpCode(b_OpCode), .Funct(b_Funct), .dbg_state(b_dbg_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        stl;
    logic [1:0]  pcsrc;
    logic        br;
    logic        taken;
    logic [31:0] btgt;
    logic [31:0] jtgt;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ready, input logic [31:0] rdata, input logic stl,
                     input logic [1:0] pcsrc, input logic br, input logic taken,
                     input logic [31:0] btgt, input logic [31:0] jtgt,
                     input logic [31:0] e_addr, input logic e_req, input logic e_valid,
                     input logic [31:0] e_instr, input logic [31:0] e_pc4);
    vec_t v;
    v.ready = ready; v.rdata = rdata; v.stl = stl; v.pcsrc = pcsrc;
    v.br = br; v.taken = taken; v.btgt = btgt; v.jtgt = jtgt;
    v.e_addr = e_addr; v.e_req = e_req; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc4 = e_pc4;
    vecs.push_back(v);
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0; PCSrc = 2'b00;
    Branch = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; jr_target = 32'h0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " addr"},  imem_addr,   32'h0);
    chk({tag, " req"},   {31'h0, imem_req}, 32'h0);
    chk({tag, " valid"}, {31'h0, id_valid}, 32'h0);
    chk({tag, " instr"}, id_instr,    32'h0);
    chk({tag, " pc4"},   id_pc_plus4, 32'h0);
  endtask

  localparam logic [31:0] I0 = 32'h0022_1820, I1 = 32'h8C43_0004, JW = 32'h0800_0040;
  localparam logic [31:0] I2 = 32'h2001_0001, JRW = 32'h03E0_0008, I3 = 32'hAC22_0008;
  localparam logic [31:0] HW = 32'h2008_0005, I4 = 32'h1022_0003, I5 = 32'h0043_2025;
  localparam logic [31:0] I6 = 32'h3C01_ABCD, I7 = 32'h0109_4020, I8 = 32'h8D2A_0000;
  localparam logic [31:0] I9 = 32'h2108_FFFF, JUNK = 32'hDEAD_BEEF;

  initial begin
    reset = 1'b0; b_reset = 1'b0;
    b_imem_ready = 1'b0; b_imem_rdata = 32'h0;
    drive_idle();

    //   rdy rdata stl pcsrc br tk btgt        jtgt          e_addr       req val e_instr e_pc4
    add(1, JUNK, 0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0000, 1, 0, 32'h0, 32'h0);
    add(1, I0,   0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0004, 1, 1, I0,    32'h0000_0004);
    add(1, I1,   0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0008, 1, 1, I1,    32'h0000_0008);
    add(1, JW,   0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_000C, 1, 1, JW,    32'h0000_000C);
    add(1, JUNK, 0, 2'b01, 0, 0, 32'h0,     32'h0,     32'h0000_0100, 1, 0, 32'h0, 32'h0);
    add(0, JUNK, 0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0100, 1, 0, 32'h0, 32'h0);
    add(1, I2,   0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0104, 1, 1, I2,    32'h0000_0104);
    add(1, JRW,  0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0108, 1, 1, JRW,   32'h0000_0108);
    add(0, JUNK, 0, 2'b10, 0, 0, 32'h0,     32'h200,   32'h0000_0108, 1, 0, 32'h0, 32'h0);
    add(0, JUNK, 0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0108, 1, 0, 32'h0, 32'h0);
    add(0, JUNK, 0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0108, 1, 0, 32'h0, 32'h0);
    add(1, JUNK, 0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0200, 1, 0, 32'h0, 32'h0);
    add(1, I3,   0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0204, 1, 1, I3,    32'h0000_0204);
    add(1, HW,   1, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0208, 0, 1, I3,    32'h0000_0204);
    add(0, JUNK, 1, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0208, 0, 1, I3,    32'h0000_0204);
    add(0, JUNK, 0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0208, 1, 1, HW,    32'h0000_0208);
    add(1, I4,   0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_020C, 1, 1, I4,    32'h0000_020C);
    add(1, JUNK, 0, 2'b00, 1, 1, 32'h300,   32'h0,     32'h0000_0300, 1, 0, 32'h0, 32'h0);
    add(1, I5,   0, 2'b00, 1, 1, 32'h500,   32'h0,     32'h0000_0304, 1, 1, I5,    32'h0000_0304);
    add(1, I6,   0, 2'b00, 1, 0, 32'h500,   32'h0,     32'h0000_0308, 1, 1, I6,    32'h0000_0308);
    add(0, JUNK, 1, 2'b01, 0, 0, 32'h0,     32'h0,     32'h0000_0308, 1, 1, I6,    32'h0000_0308);
    add(1, I7,   0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_030C, 1, 1, I7,    32'h0000_030C);
    add(1, I8,   1, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0310, 0, 1, I7,    32'h0000_030C);
    add(0, JUNK, 0, 2'b10, 0, 0, 32'h0,     32'h400,   32'h0000_0400, 1, 0, 32'h0, 32'h0);
    add(1, I9,   0, 2'b00, 0, 0, 32'h0,     32'h0,     32'h0000_0404, 1, 1, I9,    32'h0000_0404);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("in_reset");
    reset = 1'b1;
    #1;
    chk_reset_state("released");

    for (int i = 0; i < vecs.size(); i++) begin
      imem_ready = vecs[i].ready; imem_rdata = vecs[i].rdata; stall = vecs[i].stl;
      PCSrc = vecs[i].pcsrc; Branch = vecs[i].br; branch_taken = vecs[i].taken;
      branch_target = vecs[i].btgt; jr_target = vecs[i].jtgt;
      step();
      chk($sformatf("v%0d addr", i),  imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d req", i),   {31'h0, imem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d valid", i), {31'h0, id_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("v%0d instr", i), id_instr, vecs[i].e_instr);
      chk($sformatf("v%0d opcode", i), {26'h0, OpCode}, {26'h0, vecs[i].e_instr[31:26]});
      chk($sformatf("v%0d funct", i),  {26'h0, Funct},  {26'h0, vecs[i].e_instr[5:0]});
      if (vecs[i].e_valid)
        chk($sformatf("v%0d pc4", i), id_pc_plus4, vecs[i].e_pc4);
    end

    // Reset dropped while a request is waiting for imem_ready.
    drive_idle();
    step();
    chk("wait addr", imem_addr, 32'h0000_0404);
    chk("wait req", {31'h0, imem_req}, 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_state("midwait");
    step();
    reset = 1'b1;
    imem_ready = 1'b1; imem_rdata = JUNK;
    step();
    chk("restart req", {31'h0, imem_req}, 32'h1);
    chk("restart addr", imem_addr, 32'h0);
    imem_rdata = I0;
    step();
    chk("restart instr", id_instr, I0);
    chk("restart pc4", id_pc_plus4, 32'h4);
    chk("restart next addr", imem_addr, 32'h4);

    // RESET_PC at the top of the address space wraps to zero.
    b_reset = 1'b1;
    #1;
    chk("wrap reset addr", b_imem_addr, 32'hFFFF_FFFC);
    chk("wrap reset req", {31'h0, b_imem_req}, 32'h0);
    b_imem_ready = 1'b1; b_imem_rdata = JUNK;
    step();
    chk("wrap first addr", b_imem_addr, 32'hFFFF_FFFC);
    chk("wrap first req", {31'h0, b_imem_req}, 32'h1);
    b_imem_rdata = I5;
    step();
    chk("wrap instr", b_id_instr, I5);
    chk("wrap pc4", b_id_pc_plus4, 32'h0);
    chk("wrap valid", {31'h0, b_id_valid}, 32'h1);
    chk("wrap addr", b_imem_addr, 32'h0);
    b_imem_rdata = I6;
    step();
    chk("wrap2 instr", b_id_instr, I6);
    chk("wrap2 pc4", b_id_pc_plus4, 32'h4);
    chk("wrap2 addr", b_imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
